// File: rtl/wb_commit_queue_if.sv
// Bundle-in / writeback-out / hazard-query signal group for wb_commit_queue.
// The master side is the pipeline (issue + MEM); the slave side is the queue.
interface wb_commit_queue_if #(
  parameter int LANES  = 2,
  parameter int WPORTS = 1,
  parameter int DEPTH  = 4,
  parameter int DW     = 32,
  parameter int AW     = 5
);
  logic                         in_valid;
  logic                         in_ready;
  logic [LANES-1:0]             reg_write;
  logic [LANES-1:0]             mem_to_reg;
  logic [LANES*AW-1:0]          dest_reg;
  logic [LANES*DW-1:0]          alu_result;
  logic [LANES*DW-1:0]          mem_data;
  logic [WPORTS-1:0]            wb_we;
  logic [WPORTS*AW-1:0]         wb_addr;
  logic [WPORTS*DW-1:0]         wb_data;
  logic [LANES*AW-1:0]          q_addr;
  logic [LANES-1:0]             q_hit;
  logic [$clog2(DEPTH+1)-1:0]   occupancy;

  modport master (
    output in_valid, reg_write, mem_to_reg, dest_reg, alu_result, mem_data, q_addr,
    input  in_ready, wb_we, wb_addr, wb_data, q_hit, occupancy
  );

  modport slave (
    input  in_valid, reg_write, mem_to_reg, dest_reg, alu_result, mem_data, q_addr,
    output in_ready, wb_we, wb_addr, wb_data, q_hit, occupancy
  );
endinterface

// File: rtl/wb_commit_queue.sv
// Multi-slot writeback commit queue: filters and de-conflicts each issue bundle,
// compacts survivors into an in-order queue and drains WPORTS writes per cycle.
module wb_commit_queue #(
  parameter int LANES  = 2,
  parameter int WPORTS = 1,
  parameter int DEPTH  = 4,
  parameter int DW     = 32,
  parameter int AW     = 5
) (
  input  logic                clk,
  input  logic                rst,
  wb_commit_queue_if.slave    bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;

  logic [AW-1:0]        ent_addr [DEPTH];
  logic [DW-1:0]        ent_data [DEPTH];

  logic [LANES-1:0]     live;
  logic [LANES-1:0]     survive;
  logic [AW-1:0]        lane_addr [LANES];
  logic [DW-1:0]        lane_data [LANES];

  logic                 accept;
  logic [LANES-1:0]     enq_we;
  logic [PW-1:0]        enq_idx [LANES];
  logic [CW-1:0]        n_in;
  logic [CW-1:0]        n_out;

  logic [CW:0]          free_slots;
  logic [PW-1:0]        rel_pos [DEPTH];
  logic [DEPTH-1:0]     ent_valid;

  logic [WPORTS-1:0]    we_r;
  logic [WPORTS*AW-1:0] addr_r;
  logic [WPORTS*DW-1:0] data_r;

  // Lane decode: data select and null-write filter
  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_addr[i] = bus.dest_reg[i*AW +: AW];
      lane_data[i] = bus.mem_to_reg[i] ? bus.mem_data[i*DW +: DW]
                                       : bus.alu_result[i*DW +: DW];
      live[i]      = bus.reg_write[i] && (lane_addr[i] != '0);
    end
  end

  // A live lane survives only if no younger live lane in the bundle hits the same register
  always_comb begin
    survive = live;
    for (int unsigned i = 0; i < LANES; i++) begin
      for (int unsigned j = i + 1; j < LANES; j++) begin
        if (live[j] && (lane_addr[j] == lane_addr[i])) survive[i] = 1'b0;
      end
    end
  end

  assign free_slots   = (CW+1)'(DEPTH) - {1'b0, count};
  assign bus.in_ready = free_slots >= (CW+1)'(LANES);
  assign accept       = bus.in_valid && bus.in_ready;

  // Compaction: each survivor lands at wr_ptr plus the number of survivors below it
  always_comb begin
    n_in = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      enq_we[i]  = accept && survive[i];
      enq_idx[i] = wr_ptr + PW'(n_in);
      if (enq_we[i]) n_in = n_in + CW'(1);
    end
  end

  assign n_out = (count < CW'(WPORTS)) ? count : CW'(WPORTS);

  // Entry storage needs no reset; validity comes from the pointers and count
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < LANES; i++) begin
      if (enq_we[i]) begin
        ent_addr[enq_idx[i]] <= lane_addr[i];
        ent_data[enq_idx[i]] <= lane_data[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      we_r   <= '0;
      addr_r <= '0;
      data_r <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(n_in);
      rd_ptr <= rd_ptr + PW'(n_out);
      count  <= count + n_in - n_out;
      for (int unsigned p = 0; p < WPORTS; p++) begin
        if (CW'(p) < n_out) begin
          we_r[p]            <= 1'b1;
          addr_r[p*AW +: AW] <= ent_addr[rd_ptr + PW'(p)];
          data_r[p*DW +: DW] <= ent_data[rd_ptr + PW'(p)];
        end else begin
          we_r[p] <= 1'b0;
        end
      end
    end
  end

  assign bus.wb_we     = we_r;
  assign bus.wb_addr   = addr_r;
  assign bus.wb_data   = data_r;
  assign bus.occupancy = count;

  // Entry k is valid when its distance from the read pointer is below the count
  always_comb begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      rel_pos[k]   = PW'(k) - rd_ptr;
      ent_valid[k] = {{(CW-PW){1'b0}}, rel_pos[k]} < count;
    end
  end

  always_comb begin
    bus.q_hit = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (bus.q_addr[i*AW +: AW] != '0) begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
          if (ent_valid[k] && (ent_addr[k] == bus.q_addr[i*AW +: AW])) bus.q_hit[i] = 1'b1;
        end
        for (int unsigned p = 0; p < WPORTS; p++) begin
          if (we_r[p] && (addr_r[p*AW +: AW] == bus.q_addr[i*AW +: AW])) bus.q_hit[i] = 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_wb_commit_queue.sv
// Scoreboard bench for wb_commit_queue: a single-port and a dual-port instance
// receive identical bundles; a bundle is presented only when both can take it.
module tb_wb_commit_queue;
  localparam int LANES = 2;
  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                tb_valid;
  logic [LANES-1:0]    t_we, t_m2r;
  logic [LANES*AW-1:0] t_dest, t_q;
  logic [LANES*DW-1:0] t_alu, t_mem;

  wb_commit_queue_if #(.LANES(LANES), .WPORTS(1), .DEPTH(DEPTH), .DW(DW), .AW(AW)) bus1 ();
  wb_commit_queue_if #(.LANES(LANES), .WPORTS(2), .DEPTH(DEPTH), .DW(DW), .AW(AW)) bus2 ();

  assign bus1.in_valid   = tb_valid && bus1.in_ready && bus2.in_ready;
  assign bus1.reg_write  = t_we;
  assign bus1.mem_to_reg = t_m2r;
  assign bus1.dest_reg   = t_dest;
  assign bus1.alu_result = t_alu;
  assign bus1.mem_data   = t_mem;
  assign bus1.q_addr     = t_q;
  assign bus2.in_valid   = tb_valid && bus1.in_ready && bus2.in_ready;
  assign bus2.reg_write  = t_we;
  assign bus2.mem_to_reg = t_m2r;
  assign bus2.dest_reg   = t_dest;
  assign bus2.alu_result = t_alu;
  assign bus2.mem_data   = t_mem;
  assign bus2.q_addr     = t_q;

  wb_commit_queue #(.LANES(LANES), .WPORTS(1), .DEPTH(DEPTH), .DW(DW), .AW(AW)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave));
  wb_commit_queue #(.LANES(LANES), .WPORTS(2), .DEPTH(DEPTH), .DW(DW), .AW(AW)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave));

  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t exp1[$];
  wr_t exp2[$];
  wr_t e1, e2;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int wcount1  = 0;
  int last1    = 0;
  int max_occ1 = 0;
  bit gap_mode = 1'b0;
  bit seen1    = 1'b0;
  int base;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Expected writes of the bundle currently on t_*: filter r0, younger lane wins
  task automatic model_push();
    logic [AW-1:0] a;
    bit keep;
    for (int i = 0; i < LANES; i++) begin
      a = t_dest[i*AW +: AW];
      if (t_we[i] && a != 0) begin
        keep = 1'b1;
        for (int j = i + 1; j < LANES; j++)
          if (t_we[j] && t_dest[j*AW +: AW] == a) keep = 1'b0;
        if (keep) begin
          exp1.push_back({a, t_m2r[i] ? t_mem[i*DW +: DW] : t_alu[i*DW +: DW]});
          exp2.push_back({a, t_m2r[i] ? t_mem[i*DW +: DW] : t_alu[i*DW +: DW]});
        end
      end
    end
  endtask

  task automatic send(input logic [1:0] we, input logic [1:0] m2r,
                      input logic [AW-1:0] d0, input logic [AW-1:0] d1,
                      input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                      input logic [DW-1:0] m0, input logic [DW-1:0] m1);
    t_we = we; t_m2r = m2r; t_dest = {d1, d0};
    t_alu = {a1, a0}; t_mem = {m1, m0};
    tb_valid = 1'b1;
    for (int w = 0; w < 50; w++) begin
      @(negedge clk);
      if (bus1.in_ready && bus2.in_ready) begin
        model_push();
        @(posedge clk); #1;
        return;
      end
    end
    check("accept_timeout", {bus1.in_ready, bus2.in_ready}, 2'b11);
    tb_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    tb_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus1.wb_we[0]) begin
        wcount1++;
        if (exp1.size() == 0) check("dut1_spurious_we", bus1.wb_we[0], 1'b0);
        else begin
          e1 = exp1.pop_front();
          check("dut1_addr", bus1.wb_addr, e1.a);
          check("dut1_data", bus1.wb_data, e1.d);
        end
        if (gap_mode) begin
          if (seen1) check("dut1_gap", cyc - last1, 1);
          seen1 = 1'b1;
          last1 = cyc;
        end
      end
      if (gap_mode) begin
        if (bus1.occupancy >= 3) check("dut1_ready_when_full", bus1.in_ready, 1'b0);
        if (int'(bus1.occupancy) > max_occ1) max_occ1 = int'(bus1.occupancy);
        check("dut2_sustained_ready", bus2.in_ready, 1'b1);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int p = 0; p < 2; p++) begin
        if (bus2.wb_we[p]) begin
          if (exp2.size() == 0) check("dut2_spurious_we", bus2.wb_we[p], 1'b0);
          else begin
            e2 = exp2.pop_front();
            check("dut2_addr", bus2.wb_addr[p*AW +: AW], e2.a);
            check("dut2_data", bus2.wb_data[p*DW +: DW], e2.d);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tb_valid = 1'b0;
    t_we = '0; t_m2r = '0; t_dest = '0; t_alu = '0; t_mem = '0; t_q = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_occ1", bus1.occupancy, 0);
    check("rst_we1", bus1.wb_we, 0);
    check("rst_addr2", bus2.wb_addr, 0);
    check("rst_data2", bus2.wb_data, 0);
    check("rst_ready1", bus1.in_ready, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single write: latency 2 edges, one cycle on the port
    send(2'b01, 2'b00, 5'd3, 5'd0, 32'h11, 32'h0, 32'h0, 32'h0);
    tb_valid = 1'b0;
    @(negedge clk);
    check("t1_occ_after_accept", bus1.occupancy, 1);
    check("t1_we_early", bus1.wb_we, 1'b0);
    @(negedge clk);
    check("t1_we", bus1.wb_we, 1'b1);
    check("t1_addr", bus1.wb_addr, 3);
    check("t1_data", bus1.wb_data, 32'h11);
    check("t1_occ_after_drain", bus1.occupancy, 0);
    @(negedge clk);
    check("t1_we_once", bus1.wb_we, 1'b0);
    idle(2);

    // r0 filter, mem select, same-bundle conflict
    base = wcount1;
    send(2'b11, 2'b10, 5'd0, 5'd7, 32'h0, 32'hBB, 32'h0, 32'hAA);
    idle(4);
    send(2'b11, 2'b00, 5'd9, 5'd9, 32'h1, 32'h2, 32'h0, 32'h0);
    idle(4);
    check("t2_write_count", wcount1 - base, 2);

    // Hazard query: lane0 asks r5, lane1 asks r6
    t_q = {5'd6, 5'd5};
    @(negedge clk);
    check("hz_idle1", bus1.q_hit, 2'b00);
    @(posedge clk); #1;
    send(2'b01, 2'b00, 5'd5, 5'd0, 32'h55, 32'h0, 32'h0, 32'h0);
    tb_valid = 1'b0;
    @(negedge clk);
    check("hz_queued1", bus1.q_hit, 2'b01);
    check("hz_queued2", bus2.q_hit, 2'b01);
    @(negedge clk);
    check("hz_on_port1", bus1.q_hit, 2'b01);
    check("hz_on_port2", bus2.q_hit, 2'b01);
    @(negedge clk);
    check("hz_drained1", bus1.q_hit, 2'b00);
    check("hz_drained2", bus2.q_hit, 2'b00);
    t_q = '0;
    idle(2);

    // Back-to-back bundles against the single-port queue
    base = wcount1; seen1 = 1'b0; max_occ1 = 0; gap_mode = 1'b1;
    send(2'b11, 2'b00, 5'd1, 5'd2, 32'h101, 32'h102, 32'h0, 32'h0);
    send(2'b11, 2'b00, 5'd3, 5'd4, 32'h103, 32'h104, 32'h0, 32'h0);
    send(2'b11, 2'b00, 5'd5, 5'd6, 32'h105, 32'h106, 32'h0, 32'h0);
    idle(8);
    gap_mode = 1'b0;
    check("bp_max_occ", max_occ1, 3);
    check("bp_write_count", wcount1 - base, 6);

    // Dual port: both lanes leave in the same cycle, lane order on ports
    send(2'b11, 2'b00, 5'd4, 5'd8, 32'h44, 32'h88, 32'h0, 32'h0);
    tb_valid = 1'b0;
    @(negedge clk);
    check("dp_we_early", bus2.wb_we, 2'b00);
    @(negedge clk);
    check("dp_we", bus2.wb_we, 2'b11);
    check("dp_addr", bus2.wb_addr, {5'd8, 5'd4});
    idle(4);

    // Reset with writes pending
    send(2'b11, 2'b00, 5'd10, 5'd11, 32'h10, 32'h11, 32'h0, 32'h0);
    send(2'b11, 2'b00, 5'd12, 5'd13, 32'h12, 32'h13, 32'h0, 32'h0);
    tb_valid = 1'b0;
    t_q = {5'd13, 5'd0};
    @(negedge clk);
    check("mid_occ1", bus1.occupancy, 3);
    check("mid_hit1", bus1.q_hit, 2'b10);
    check("mid_hit2", bus2.q_hit, 2'b10);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_we1", bus1.wb_we, 1'b0);
    check("mid_rst_we2", bus2.wb_we, 2'b00);
    check("mid_rst_occ1", bus1.occupancy, 0);
    check("mid_rst_occ2", bus2.occupancy, 0);
    check("mid_rst_hit1", bus1.q_hit, 2'b00);
    check("mid_rst_hit2", bus2.q_hit, 2'b00);
    check("mid_rst_addr1", bus1.wb_addr, 0);
    check("mid_rst_ready1", bus1.in_ready, 1'b1);
    exp1.delete();
    exp2.delete();
    #1 rst = 1'b0;
    base = wcount1;
    idle(6);
    check("mid_no_stale", wcount1 - base, 0);
    t_q = '0;

    check("drain_empty1", exp1.size(), 0);
    check("drain_empty2", exp2.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
